// File: rtl/bank_sc_pipe_pkg.sv
// Shared bank package: opcode constants, data width, and the FSM state
// encoding used by the bank store/read pipe (bank_sc_pipe).
package bank_sc_pipe_pkg;

    localparam int SC_DATA_W = 128;
    localparam int SC_CNT_W  = 16;

    localparam logic [2:0] SC_OP_READ  = 3'd0;
    localparam logic [2:0] SC_OP_WRITE = 3'd1;

    localparam logic [SC_CNT_W-1:0] SC_CNT_ONE = SC_CNT_W'(1);

    typedef enum logic [2:0] {
        SC_IDLE  = 3'd0,
        SC_WBRD  = 3'd1,
        SC_RAMWR = 3'd2,
        SC_RAMRD = 3'd3,
        SC_RESP  = 3'd4
    } sc_state_e;

    // The state-update bus carries {set, way}; the offset bit is dropped.
    function automatic logic [5:0] sc_set_way(input logic [6:0] set_way_offset);
        return set_way_offset[6:1];
    endfunction

endpackage

// File: rtl/bank_sc_perf_cnt.sv
// Pair of 16-bit event counters (read accepts, write accepts) for the bank
// pipe. Counters wrap naturally at 16'hFFFF. The load port lets both
// counters be preset together; load wins over an increment in the same cycle.
module bank_sc_perf_cnt
    import bank_sc_pipe_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                inc_rd_i,
    input  logic                inc_wr_i,
    input  logic                load_i,
    input  logic [SC_CNT_W-1:0] load_val_i,
    output logic [SC_CNT_W-1:0] rd_cnt_o,
    output logic [SC_CNT_W-1:0] wr_cnt_o
);

    logic [1:0] w_inc;

    assign w_inc = {inc_wr_i, inc_rd_i};

    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        logic [SC_CNT_W-1:0] r_cnt;

        // One counter per event type: preset, else count on its event.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_cnt <= '0;
            end else if (load_i) begin
                r_cnt <= load_val_i;
            end else if (w_inc[gi]) begin
                r_cnt <= r_cnt + SC_CNT_ONE;
            end
        end
    end

    assign rd_cnt_o = g_cnt[0].r_cnt;
    assign wr_cnt_o = g_cnt[1].r_cnt;

endmodule

// File: rtl/bank_sc_pipe.sv
// Bank store/read pipe: takes one ISU request at a time and sequences it
// through the write buffer, the data SRAM and the xbar response port.
//   READ : IDLE -> RAMRD -> RESP (held until xbar ready) -> IDLE
//   WRITE: IDLE -> WBRD -> RAMWR -> IDLE
//   other opcodes: consumed in IDLE, sc_err_o pulses the next cycle.
// Optional macro SC_PERF_CNT_EN adds read/write accept counters.
module bank_sc_pipe
    import bank_sc_pipe_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 isu_sc_valid_i,
    output logic                 isu_sc_ready_o,
    input  logic [1:0]           isu_sc_channel_id_i,
    input  logic [2:0]           isu_sc_opcode_i,
    input  logic [6:0]           isu_sc_set_way_offset_i,
    input  logic [7:0]           isu_sc_wbuffer_id_i,
    input  logic [2:0]           isu_sc_xbar_rob_num_i,
    input  logic [1:0]           isu_sc_cacheline_dirty_offset0_i,
    input  logic [1:0]           isu_sc_cacheline_dirty_offset1_i,
    output logic                 sc_ram_en_o,
    output logic                 sc_ram_we_o,
    output logic [6:0]           sc_ram_addr_o,
    output logic [SC_DATA_W-1:0] sc_ram_wdata_o,
    input  logic [SC_DATA_W-1:0] ram_sc_rdata_i,
    output logic                 sc_wb_rd_en_o,
    output logic [7:0]           sc_wb_rd_id_o,
    input  logic [SC_DATA_W-1:0] wb_sc_rdata_i,
    output logic                 sc_xbar_valid_o,
    input  logic                 xbar_sc_ready_i,
    output logic [1:0]           sc_xbar_ch_id_o,
    output logic [2:0]           sc_xbar_rob_num_o,
    output logic [SC_DATA_W-1:0] sc_xbar_rdata_o,
    output logic                 sc_state_upd_valid_o,
    output logic [5:0]           sc_state_upd_set_way_o,
    output logic [1:0]           sc_state_upd_offset0_o,
    output logic [1:0]           sc_state_upd_offset1_o,
    output logic                 sc_err_o
`ifdef SC_PERF_CNT_EN
    ,
    output logic [SC_CNT_W-1:0]  sc_perf_rd_cnt_o,
    output logic [SC_CNT_W-1:0]  sc_perf_wr_cnt_o
`endif
);

    sc_state_e            r_state;
    sc_state_e            w_state_next;

    logic [1:0]           r_ch;
    logic [6:0]           r_addr;
    logic [7:0]           r_wbid;
    logic [2:0]           r_rob;
    logic [1:0]           r_dirty0;
    logic [1:0]           r_dirty1;
    logic [SC_DATA_W-1:0] r_rdata;
    logic                 r_resp_first;
    logic                 r_err;

    logic                 w_ready;
    logic                 w_accept;
    logic                 w_is_read;
    logic                 w_is_write;

    // Ready is a pure function of state so accept never loops back into it.
    assign w_ready        = (r_state == SC_IDLE) & ~rst_i;
    assign isu_sc_ready_o = w_ready;
    assign w_accept       = isu_sc_valid_i & w_ready;
    assign w_is_read      = (isu_sc_opcode_i == SC_OP_READ);
    assign w_is_write     = (isu_sc_opcode_i == SC_OP_WRITE);
    assign sc_err_o       = r_err;

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= SC_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Capture every request field on accept; they stay put for the whole transaction.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ch     <= '0;
            r_addr   <= '0;
            r_wbid   <= '0;
            r_rob    <= '0;
            r_dirty0 <= '0;
            r_dirty1 <= '0;
        end else if (w_accept) begin
            r_ch     <= isu_sc_channel_id_i;
            r_addr   <= isu_sc_set_way_offset_i;
            r_wbid   <= isu_sc_wbuffer_id_i;
            r_rob    <= isu_sc_xbar_rob_num_i;
            r_dirty0 <= isu_sc_cacheline_dirty_offset0_i;
            r_dirty1 <= isu_sc_cacheline_dirty_offset1_i;
        end
    end

    // SRAM data arrives in the first RESP cycle: it is passed straight
    // through then and latched, so a stalled response keeps it stable.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rdata      <= '0;
            r_resp_first <= 1'b0;
        end else begin
            r_resp_first <= (w_state_next == SC_RESP) && (r_state != SC_RESP);
            if ((r_state == SC_RESP) && r_resp_first) begin
                r_rdata <= ram_sc_rdata_i;
            end
        end
    end

    // Unknown opcodes are flagged one cycle after they are consumed.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_accept & ~w_is_read & ~w_is_write;
        end
    end

    // Next-state and per-state output decode; every output idles at 0.
    always_comb begin
        w_state_next           = r_state;
        sc_ram_en_o            = 1'b0;
        sc_ram_we_o            = 1'b0;
        sc_ram_addr_o          = '0;
        sc_ram_wdata_o         = '0;
        sc_wb_rd_en_o          = 1'b0;
        sc_wb_rd_id_o          = '0;
        sc_xbar_valid_o        = 1'b0;
        sc_xbar_ch_id_o        = '0;
        sc_xbar_rob_num_o      = '0;
        sc_xbar_rdata_o        = '0;
        sc_state_upd_valid_o   = 1'b0;
        sc_state_upd_set_way_o = '0;
        sc_state_upd_offset0_o = '0;
        sc_state_upd_offset1_o = '0;
        case (r_state)
            SC_IDLE: begin
                if (w_accept && w_is_read) begin
                    w_state_next = SC_RAMRD;
                end else if (w_accept && w_is_write) begin
                    w_state_next = SC_WBRD;
                end
            end
            SC_RAMRD: begin
                sc_ram_en_o   = 1'b1;
                sc_ram_addr_o = r_addr;
                w_state_next  = SC_RESP;
            end
            SC_RESP: begin
                sc_xbar_valid_o   = 1'b1;
                sc_xbar_ch_id_o   = r_ch;
                sc_xbar_rob_num_o = r_rob;
                sc_xbar_rdata_o   = r_resp_first ? ram_sc_rdata_i : r_rdata;
                if (xbar_sc_ready_i) begin
                    w_state_next = SC_IDLE;
                end
            end
            SC_WBRD: begin
                sc_wb_rd_en_o = 1'b1;
                sc_wb_rd_id_o = r_wbid;
                w_state_next  = SC_RAMWR;
            end
            SC_RAMWR: begin
                sc_ram_en_o            = 1'b1;
                sc_ram_we_o            = 1'b1;
                sc_ram_addr_o          = r_addr;
                sc_ram_wdata_o         = wb_sc_rdata_i;
                sc_state_upd_valid_o   = 1'b1;
                sc_state_upd_set_way_o = sc_set_way(r_addr);
                sc_state_upd_offset0_o = r_dirty0;
                sc_state_upd_offset1_o = r_dirty1;
                w_state_next           = SC_IDLE;
            end
            default: begin
                w_state_next = SC_IDLE;
            end
        endcase
    end

`ifdef SC_PERF_CNT_EN
    bank_sc_perf_cnt u_perf_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .inc_rd_i   (w_accept & w_is_read),
        .inc_wr_i   (w_accept & w_is_write),
        .load_i     (1'b0),
        .load_val_i ({SC_CNT_W{1'b0}}),
        .rd_cnt_o   (sc_perf_rd_cnt_o),
        .wr_cnt_o   (sc_perf_wr_cnt_o)
    );
`endif

endmodule

// File: tb/tb_bank_sc_pipe.sv
// Bench for bank_sc_pipe: directed vector table, a reset-during-write
// sequence, randomized transactions checked against a memory-level model,
// and a standalone check of the perf counter (including wrap).
module tb_bank_sc_pipe;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         isu_sc_valid_i;
    logic         isu_sc_ready_o;
    logic [1:0]   isu_sc_channel_id_i;
    logic [2:0]   isu_sc_opcode_i;
    logic [6:0]   isu_sc_set_way_offset_i;
    logic [7:0]   isu_sc_wbuffer_id_i;
    logic [2:0]   isu_sc_xbar_rob_num_i;
    logic [1:0]   isu_sc_cacheline_dirty_offset0_i;
    logic [1:0]   isu_sc_cacheline_dirty_offset1_i;
    logic         sc_ram_en_o;
    logic         sc_ram_we_o;
    logic [6:0]   sc_ram_addr_o;
    logic [127:0] sc_ram_wdata_o;
    logic [127:0] ram_sc_rdata_i;
    logic         sc_wb_rd_en_o;
    logic [7:0]   sc_wb_rd_id_o;
    logic [127:0] wb_sc_rdata_i;
    logic         sc_xbar_valid_o;
    logic         xbar_sc_ready_i;
    logic [1:0]   sc_xbar_ch_id_o;
    logic [2:0]   sc_xbar_rob_num_o;
    logic [127:0] sc_xbar_rdata_o;
    logic         sc_state_upd_valid_o;
    logic [5:0]   sc_state_upd_set_way_o;
    logic [1:0]   sc_state_upd_offset0_o;
    logic [1:0]   sc_state_upd_offset1_o;
    logic         sc_err_o;
`ifdef SC_PERF_CNT_EN
    logic [15:0]  sc_perf_rd_cnt_o;
    logic [15:0]  sc_perf_wr_cnt_o;
`endif

    // Standalone counter instance (preload and wrap).
    logic         c_rst, c_inc_rd, c_inc_wr, c_load;
    logic [15:0]  c_load_val, c_rd, c_wr;

    int n_checks = 0;
    int n_err    = 0;
    int n_hs     = 0;
    int n_rd_total = 0;
    int exp_rd_cnt = 0;
    int exp_wr_cnt = 0;

    logic [127:0] ram_mem [128];
    logic [127:0] ref_mem [128];
    logic [127:0] wb_mem  [256];

    logic [292:0] all_outs;

    always #5 clk_i = ~clk_i;

    bank_sc_pipe dut (
        .clk_i                            (clk_i),
        .rst_i                            (rst_i),
        .isu_sc_valid_i                   (isu_sc_valid_i),
        .isu_sc_ready_o                   (isu_sc_ready_o),
        .isu_sc_channel_id_i              (isu_sc_channel_id_i),
        .isu_sc_opcode_i                  (isu_sc_opcode_i),
        .isu_sc_set_way_offset_i          (isu_sc_set_way_offset_i),
        .isu_sc_wbuffer_id_i              (isu_sc_wbuffer_id_i),
        .isu_sc_xbar_rob_num_i            (isu_sc_xbar_rob_num_i),
        .isu_sc_cacheline_dirty_offset0_i (isu_sc_cacheline_dirty_offset0_i),
        .isu_sc_cacheline_dirty_offset1_i (isu_sc_cacheline_dirty_offset1_i),
        .sc_ram_en_o                      (sc_ram_en_o),
        .sc_ram_we_o                      (sc_ram_we_o),
        .sc_ram_addr_o                    (sc_ram_addr_o),
        .sc_ram_wdata_o                   (sc_ram_wdata_o),
        .ram_sc_rdata_i                   (ram_sc_rdata_i),
        .sc_wb_rd_en_o                    (sc_wb_rd_en_o),
        .sc_wb_rd_id_o                    (sc_wb_rd_id_o),
        .wb_sc_rdata_i                    (wb_sc_rdata_i),
        .sc_xbar_valid_o                  (sc_xbar_valid_o),
        .xbar_sc_ready_i                  (xbar_sc_ready_i),
        .sc_xbar_ch_id_o                  (sc_xbar_ch_id_o),
        .sc_xbar_rob_num_o                (sc_xbar_rob_num_o),
        .sc_xbar_rdata_o                  (sc_xbar_rdata_o),
        .sc_state_upd_valid_o             (sc_state_upd_valid_o),
        .sc_state_upd_set_way_o           (sc_state_upd_set_way_o),
        .sc_state_upd_offset0_o           (sc_state_upd_offset0_o),
        .sc_state_upd_offset1_o           (sc_state_upd_offset1_o),
        .sc_err_o                         (sc_err_o)
`ifdef SC_PERF_CNT_EN
        ,
        .sc_perf_rd_cnt_o                 (sc_perf_rd_cnt_o),
        .sc_perf_wr_cnt_o                 (sc_perf_wr_cnt_o)
`endif
    );

    bank_sc_perf_cnt u_cnt (
        .clk_i      (clk_i),
        .rst_i      (c_rst),
        .inc_rd_i   (c_inc_rd),
        .inc_wr_i   (c_inc_wr),
        .load_i     (c_load),
        .load_val_i (c_load_val),
        .rd_cnt_o   (c_rd),
        .wr_cnt_o   (c_wr)
    );

    assign all_outs = {isu_sc_ready_o, sc_ram_en_o, sc_ram_we_o, sc_ram_addr_o, sc_ram_wdata_o,
                       sc_wb_rd_en_o, sc_wb_rd_id_o, sc_xbar_valid_o, sc_xbar_ch_id_o,
                       sc_xbar_rob_num_o, sc_xbar_rdata_o, sc_state_upd_valid_o,
                       sc_state_upd_set_way_o, sc_state_upd_offset0_o, sc_state_upd_offset1_o,
                       sc_err_o};

    // Data SRAM model: registered read, write on enable+we.
    always @(posedge clk_i) begin
        if (sc_ram_en_o) begin
            if (sc_ram_we_o) ram_mem[sc_ram_addr_o] <= sc_ram_wdata_o;
            else             ram_sc_rdata_i <= ram_mem[sc_ram_addr_o];
        end
    end

    // Write-buffer model: registered read.
    always @(posedge clk_i) begin
        if (sc_wb_rd_en_o) wb_sc_rdata_i <= wb_mem[sc_wb_rd_id_o];
    end

    // Count xbar handshakes.
    always @(posedge clk_i) begin
        if (sc_xbar_valid_o && xbar_sc_ready_i) n_hs <= n_hs + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [299:0] act, input logic [299:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic chk_perf();
`ifdef SC_PERF_CNT_EN
        chk("perf_cnt", 300'({sc_perf_rd_cnt_o, sc_perf_wr_cnt_o}),
            300'({16'(exp_rd_cnt), 16'(exp_wr_cnt)}));
`endif
    endtask

    // One full transaction, entered and left at a negedge in IDLE.
    task automatic run_txn(input logic [2:0] op, input logic [6:0] addr, input logic [1:0] ch,
                           input logic [2:0] rob, input logic [7:0] wbid, input logic [1:0] d0,
                           input logic [1:0] d1, input int stall, input logic exp_err,
                           input logic [5:0] exp_sw);
        logic [127:0] exp_data;
        chk("idle_ready", 300'(isu_sc_ready_o), 300'(1'b1));
        isu_sc_valid_i                   = 1'b1;
        isu_sc_opcode_i                  = op;
        isu_sc_set_way_offset_i          = addr;
        isu_sc_channel_id_i              = ch;
        isu_sc_xbar_rob_num_i            = rob;
        isu_sc_wbuffer_id_i              = wbid;
        isu_sc_cacheline_dirty_offset0_i = d0;
        isu_sc_cacheline_dirty_offset1_i = d1;
        @(posedge clk_i);
        @(negedge clk_i);
        // Scramble the request bus so only captured values can pass.
        isu_sc_valid_i                   = 1'b0;
        isu_sc_opcode_i                  = 3'($urandom);
        isu_sc_set_way_offset_i          = 7'($urandom);
        isu_sc_channel_id_i              = 2'($urandom);
        isu_sc_xbar_rob_num_i            = 3'($urandom);
        isu_sc_wbuffer_id_i              = 8'($urandom);
        isu_sc_cacheline_dirty_offset0_i = 2'($urandom);
        isu_sc_cacheline_dirty_offset1_i = 2'($urandom);
        if (op == 3'd0) begin
            exp_rd_cnt = (exp_rd_cnt + 1) % 65536;
            n_rd_total++;
            exp_data = ref_mem[addr];
            chk("rd_ramrd", 300'({sc_ram_en_o, sc_ram_we_o, sc_ram_addr_o, sc_wb_rd_en_o,
                                  sc_xbar_valid_o, isu_sc_ready_o, sc_err_o}),
                300'({1'b1, 1'b0, addr, 1'b0, 1'b0, 1'b0, 1'b0}));
            @(negedge clk_i);
            for (int s = 0; s <= stall; s++) begin
                chk("rd_resp", 300'({sc_xbar_valid_o, sc_xbar_ch_id_o, sc_xbar_rob_num_o,
                                     sc_xbar_rdata_o, isu_sc_ready_o, sc_ram_en_o,
                                     sc_wb_rd_en_o, sc_state_upd_valid_o}),
                    300'({1'b1, ch, rob, exp_data, 1'b0, 1'b0, 1'b0, 1'b0}));
                xbar_sc_ready_i = (s == stall);
                @(negedge clk_i);
            end
            xbar_sc_ready_i = 1'b0;
            chk("rd_done", 300'({sc_xbar_valid_o, isu_sc_ready_o}), 300'(2'b01));
            $display("txn READ  addr=%h ch=%0d rob=%0d stall=%0d data=%h", addr, ch, rob, stall, exp_data);
        end else if (op == 3'd1) begin
            exp_wr_cnt = (exp_wr_cnt + 1) % 65536;
            chk("wr_wbrd", 300'({sc_wb_rd_en_o, sc_wb_rd_id_o, sc_ram_en_o, sc_xbar_valid_o,
                                 sc_state_upd_valid_o, isu_sc_ready_o, sc_err_o}),
                300'({1'b1, wbid, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}));
            @(negedge clk_i);
            chk("wr_ramwr", 300'({sc_ram_en_o, sc_ram_we_o, sc_ram_addr_o, sc_ram_wdata_o,
                                  sc_state_upd_valid_o, sc_state_upd_set_way_o,
                                  sc_state_upd_offset0_o, sc_state_upd_offset1_o,
                                  sc_wb_rd_en_o, sc_xbar_valid_o, isu_sc_ready_o}),
                300'({1'b1, 1'b1, addr, wb_mem[wbid], 1'b1, exp_sw, d0, d1,
                      1'b0, 1'b0, 1'b0}));
            ref_mem[addr] = wb_mem[wbid];
            @(negedge clk_i);
            chk("wr_done", 300'({isu_sc_ready_o, sc_ram_en_o, sc_state_upd_valid_o}), 300'(3'b100));
            $display("txn WRITE addr=%h wbid=%h d0=%b d1=%b data=%h", addr, wbid, d0, d1, wb_mem[wbid]);
        end else begin
            chk("err_pulse", 300'({sc_err_o, sc_ram_en_o, sc_wb_rd_en_o, sc_xbar_valid_o,
                                   sc_state_upd_valid_o, isu_sc_ready_o}),
                300'({exp_err, 5'b00001}));
            @(negedge clk_i);
            chk("err_clear", 300'({sc_err_o, sc_ram_en_o, sc_wb_rd_en_o, sc_xbar_valid_o}), 300'(4'b0));
            $display("txn OTHER op=%0d err pulse seen=%0d", op, exp_err);
        end
        chk_perf();
    endtask

    typedef struct {
        logic [2:0] op;
        logic [6:0] addr;
        logic [1:0] ch;
        logic [2:0] rob;
        logic [7:0] wbid;
        logic [1:0] d0;
        logic [1:0] d1;
        int         stall;
        logic       exp_err;
        logic [5:0] exp_sw;
    } vec_t;

    vec_t vecs [8];

    initial begin
        logic [127:0] old_data;
        logic [2:0]   rop;
        logic [6:0]   raddr;
        logic [15:0]  e_rd, e_wr;
        int           r;

        vecs[0] = '{op:3'd0, addr:7'h2B, ch:2'd2, rob:3'd5, wbid:8'h00, d0:2'b00, d1:2'b00, stall:0,  exp_err:1'b0, exp_sw:6'h15};
        vecs[1] = '{op:3'd1, addr:7'h41, ch:2'd0, rob:3'd0, wbid:8'h13, d0:2'b11, d1:2'b01, stall:0,  exp_err:1'b0, exp_sw:6'h20};
        vecs[2] = '{op:3'd0, addr:7'h41, ch:2'd1, rob:3'd3, wbid:8'h00, d0:2'b00, d1:2'b00, stall:10, exp_err:1'b0, exp_sw:6'h20};
        vecs[3] = '{op:3'd5, addr:7'h10, ch:2'd1, rob:3'd1, wbid:8'h05, d0:2'b10, d1:2'b10, stall:0,  exp_err:1'b1, exp_sw:6'h08};
        vecs[4] = '{op:3'd7, addr:7'h7F, ch:2'd3, rob:3'd7, wbid:8'hFF, d0:2'b11, d1:2'b11, stall:0,  exp_err:1'b1, exp_sw:6'h3F};
        vecs[5] = '{op:3'd1, addr:7'h7F, ch:2'd3, rob:3'd7, wbid:8'hFF, d0:2'b00, d1:2'b10, stall:0,  exp_err:1'b0, exp_sw:6'h3F};
        vecs[6] = '{op:3'd0, addr:7'h7F, ch:2'd3, rob:3'd7, wbid:8'h00, d0:2'b00, d1:2'b00, stall:1,  exp_err:1'b0, exp_sw:6'h3F};
        vecs[7] = '{op:3'd0, addr:7'h00, ch:2'd0, rob:3'd0, wbid:8'h00, d0:2'b00, d1:2'b00, stall:2,  exp_err:1'b0, exp_sw:6'h00};

        for (int i = 0; i < 128; i++) begin
            ram_mem[i] = {$urandom, $urandom, $urandom, $urandom};
            ref_mem[i] = ram_mem[i];
        end
        for (int i = 0; i < 256; i++) wb_mem[i] = {$urandom, $urandom, $urandom, $urandom};
        wb_mem[8'h13] = 128'h1234;
        ram_mem[7'h2B] = {16{8'hA5}};
        ref_mem[7'h2B] = {16{8'hA5}};

        rst_i = 1'b1;
        c_rst = 1'b1;
        c_inc_rd = 1'b0; c_inc_wr = 1'b0; c_load = 1'b0; c_load_val = 16'h0;
        isu_sc_valid_i = 1'b0; isu_sc_opcode_i = 3'd0; isu_sc_set_way_offset_i = 7'd0;
        isu_sc_channel_id_i = 2'd0; isu_sc_xbar_rob_num_i = 3'd0; isu_sc_wbuffer_id_i = 8'd0;
        isu_sc_cacheline_dirty_offset0_i = 2'd0; isu_sc_cacheline_dirty_offset1_i = 2'd0;
        xbar_sc_ready_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("reset_outputs", 300'(all_outs), 300'(0));
        rst_i = 1'b0;
        c_rst = 1'b0;
        @(negedge clk_i);
        chk_perf();

        // Directed vectors.
        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i].op, vecs[i].addr, vecs[i].ch, vecs[i].rob, vecs[i].wbid,
                    vecs[i].d0, vecs[i].d1, vecs[i].stall, vecs[i].exp_err, vecs[i].exp_sw);
        end

        // Reset while the pipe sits in WBRD: the write must be lost.
        old_data = ram_mem[7'h33];
        wb_mem[8'h22] = ~old_data;
        isu_sc_valid_i = 1'b1; isu_sc_opcode_i = 3'd1;
        isu_sc_set_way_offset_i = 7'h33; isu_sc_wbuffer_id_i = 8'h22;
        @(posedge clk_i);
        @(negedge clk_i);
        isu_sc_valid_i = 1'b0;
        chk("rst_wbrd_entered", 300'({sc_wb_rd_en_o, sc_wb_rd_id_o}), 300'({1'b1, 8'h22}));
        rst_i = 1'b1;
        #1;
        chk("rst_mid_outputs", 300'(all_outs), 300'(0));
        @(negedge clk_i);
        chk("rst_hold_outputs", 300'(all_outs), 300'(0));
        rst_i = 1'b0;
        exp_rd_cnt = 0;
        exp_wr_cnt = 0;
        @(negedge clk_i);
        @(negedge clk_i);
        chk("rst_no_ram_write", 300'(ram_mem[7'h33]), 300'(old_data));
        chk_perf();
        $display("txn RESET during WBRD, write to addr 33 discarded");
        run_txn(3'd0, 7'h33, 2'd1, 3'd2, 8'h00, 2'b00, 2'b00, 0, 1'b0, 6'h19);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 4)      rop = 3'd0;
            else if (r < 8) rop = 3'd1;
            else            rop = 3'(2 + $urandom_range(0, 5));
            raddr = 7'($urandom);
            run_txn(rop, raddr, 2'($urandom), 3'($urandom), 8'($urandom), 2'($urandom),
                    2'($urandom), int'($urandom_range(0, 3)), (rop > 3'd1), raddr[6:1]);
        end

        chk("xbar_handshakes", 300'(n_hs), 300'(n_rd_total));

        // Standalone counter: count, preload, wrap.
        chk("cnt_reset", 300'({c_rd, c_wr}), 300'(0));
        e_rd = 16'd0; e_wr = 16'd0;
        for (int i = 0; i < 5; i++) begin
            c_inc_rd = (i < 3);
            c_inc_wr = (i >= 3);
            @(negedge clk_i);
            if (i < 3) e_rd = e_rd + 16'd1;
            else       e_wr = e_wr + 16'd1;
        end
        c_inc_rd = 1'b0; c_inc_wr = 1'b0;
        chk("cnt_3rd_2wr", 300'({c_rd, c_wr}), 300'({e_rd, e_wr}));
        c_load = 1'b1; c_load_val = 16'hFFFF;
        @(negedge clk_i);
        c_load = 1'b0;
        e_rd = 16'hFFFF; e_wr = 16'hFFFF;
        chk("cnt_preload", 300'({c_rd, c_wr}), 300'({e_rd, e_wr}));
        c_inc_rd = 1'b1;
        @(negedge clk_i);
        c_inc_rd = 1'b0;
        e_rd = e_rd + 16'd1;
        chk("cnt_wrap_rd", 300'({c_rd, c_wr}), 300'({e_rd, e_wr}));
        c_inc_wr = 1'b1;
        @(negedge clk_i);
        c_inc_wr = 1'b0;
        e_wr = e_wr + 16'd1;
        chk("cnt_wrap_wr", 300'({c_rd, c_wr}), 300'({e_rd, e_wr}));
        $display("txn COUNTER rd=%h wr=%h", c_rd, c_wr);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/bank_sc_pipe.md
BANK_SC_PIPE -- requirements
Module: bank_sc_pipe

Interface
REQ-001 SHALL have these ports: clk_i in 1, the single clock; rst_i in 1, reset, asynchronous and active-high.
REQ-002 SHALL have these ISU issue ports: isu_sc_valid_i in 1; isu_sc_ready_o out 1; isu_sc_channel_id_i in 2; isu_sc_opcode_i in 3; isu_sc_set_way_offset_i in 7 ({set[6:4], way[3:1], offset[0]}); isu_sc_wbuffer_id_i in 8; isu_sc_xbar_rob_num_i in 3; isu_sc_cacheline_dirty_offset0_i in 2; isu_sc_cacheline_dirty_offset1_i in 2.
REQ-003 SHALL have these data-SRAM ports: sc_ram_en_o out 1; sc_ram_we_o out 1; sc_ram_addr_o out 7; sc_ram_wdata_o out 128; ram_sc_rdata_i in 128, valid one cycle after a read enable.
REQ-004 SHALL have these write-buffer ports: sc_wb_rd_en_o out 1; sc_wb_rd_id_o out 8; wb_sc_rdata_i in 128, valid one cycle after sc_wb_rd_en_o.
REQ-005 SHALL have these xbar response ports: sc_xbar_valid_o out 1; xbar_sc_ready_i in 1; sc_xbar_ch_id_o out 2; sc_xbar_rob_num_o out 3; sc_xbar_rdata_o out 128.
REQ-006 SHALL have these state-update and error ports: sc_state_upd_valid_o out 1; sc_state_upd_set_way_o out 6; sc_state_upd_offset0_o out 2; sc_state_upd_offset1_o out 2; sc_err_o out 1.

Function
REQ-007 SHALL implement the FSM states IDLE, WBRD, RAMWR, RAMRD and RESP, and SHALL hold one request at a time.
REQ-008 SHALL drive isu_sc_ready_o=1 only in IDLE; accept = isu_sc_valid_i & isu_sc_ready_o; all request fields are captured on accept.
REQ-009 SHALL handle an accepted READ (opcode 3'd0) as follows: IDLE->RAMRD; in RAMRD assert sc_ram_en_o=1, sc_ram_we_o=0, sc_ram_addr_o=captured set_way_offset; go ->RESP next cycle.
REQ-010 SHALL, on entry to RESP, register ram_sc_rdata_i into sc_xbar_rdata_o and hold sc_xbar_valid_o=1 with ch_id, rob_num and data stable until xbar_sc_ready_i=1, then go ->IDLE.
REQ-011 SHALL handle an accepted WRITE (opcode 3'd1) as follows: IDLE->WBRD asserting sc_wb_rd_en_o=1, sc_wb_rd_id_o=captured wbuffer_id; next cycle go ->RAMWR asserting sc_ram_en_o=1, sc_ram_we_o=1, sc_ram_addr_o=captured address, sc_ram_wdata_o=wb_sc_rdata_i; then go ->IDLE.
REQ-012 SHALL, in the RAMWR cycle, pulse sc_state_upd_valid_o for one cycle with set_way=captured[6:1] and the captured dirty offset0/offset1 states.
REQ-013 SHALL consume any other opcode in one cycle (stay in IDLE) with no SRAM, wbuffer or xbar activity, and SHALL pulse sc_err_o the cycle after accept.
REQ-014 SHALL give the following fixed latencies: READ accept to sc_xbar_valid_o = 2 cycles; WRITE accept to SRAM write = 2 cycles; READ ready back-to-back = 3 cycles minimum; WRITE = 3 cycles.
REQ-015 SHALL keep outputs stable under xbar back-pressure; a response SHALL never be dropped, and ready stays 0 for the whole stall.
REQ-016 SHALL keep sc_ram_en_o, sc_wb_rd_en_o and sc_state_upd_valid_o at 0 in all states not named above.

Reset
REQ-017 SHALL, on rst_i=1 at any time including mid-transaction, put the FSM in IDLE and clear all outputs and captured registers to 0, except isu_sc_ready_o, which SHALL read 1 after release; the in-flight request is discarded.
REQ-018 SHALL drive isu_sc_ready_o=0 while rst_i=1.

Configuration
REQ-019 SHALL, with SC_PERF_CNT_EN defined, add outputs sc_perf_rd_cnt_o[15:0] and sc_perf_wr_cnt_o[15:0], counting accepted READs and WRITEs, wrapping 16'hFFFF->0, and reset to 0.
REQ-020 SHALL, without SC_PERF_CNT_EN, have no counter ports and no counter logic.

Structure
REQ-021 SHALL take opcode constants (SC_OP_READ=3'd0, SC_OP_WRITE=3'd1), the FSM state encoding and the 128-bit data width from the shared bank package.
REQ-022 SHALL place the FSM, capture registers and datapath in a single module; the perf counter SHALL be one sub-module, bank_sc_perf_cnt.

Verification
REQ-023 SHALL pass this scenario: READ addr 7'h2B, ch 2, rob 5, ram data 128'hA5..A5, ready=1 -> sc_xbar_valid_o at accept+2 carrying ch=2, rob=5, data A5..A5; ready_o returns at accept+3.
REQ-024 SHALL pass this scenario: WRITE wbuffer_id 8'h13, addr 7'h41, dirty states 2'b11/2'b01, wb data 128'h1234 -> wb read id 8'h13 at +1; RAM write addr 7'h41 data 128'h1234 at +2; state_upd set_way 6'h20 with 11/01.
REQ-025 SHALL pass this scenario: READ with xbar_sc_ready_i held 0 for 10 cycles -> valid and data stable throughout, ready_o=0, single handshake, then IDLE.
REQ-026 SHALL pass this scenario: opcode 3'd5 -> sc_err_o pulses one cycle after accept, and no RAM, wbuffer or xbar activity occurs.
REQ-027 SHALL pass this scenario: rst_i asserted during WBRD -> no RAM write, all outputs 0, and after release a new READ completes normally.
REQ-028 SHALL pass this scenario with SC_PERF_CNT_EN defined: 3 READs and 2 WRITEs -> rd_cnt=3, wr_cnt=2; a counter preloaded to 16'hFFFF wraps to 0.
